// File: rtl/pixel_buffer_pkg.sv
// Shared rotate package: tile buffer depth, fill-state encodings and RGB lane indices.
package pixel_buffer_pkg;

    localparam int PB_DEPTH    = 192;
    localparam int PB_AW       = 8;
    localparam int PB_WR_LANES = 4;
    localparam int PB_RD_LANES = 3;

    localparam int PB_LANE_R = 0;
    localparam int PB_LANE_G = 1;
    localparam int PB_LANE_B = 2;

    typedef enum logic [1:0] {
        PB_EMPTY   = 2'h0,
        PB_FILLING = 2'h1,
        PB_FULL    = 2'h2
    } pb_state_e;

endpackage

// File: rtl/pixel_buffer_ram.sv
// Byte array with four write lanes and three registered read-first read lanes.
module pixel_buffer_ram
    import pixel_buffer_pkg::*;
#(
    parameter int P_DEPTH = PB_DEPTH,
    parameter int P_AW    = PB_AW
) (
    input  logic                              clk_i,
    input  logic                              rst_i,
    input  logic [PB_WR_LANES-1:0]            wr_en_i,
    input  logic [PB_WR_LANES*P_AW-1:0]       wr_addr_i,
    input  logic [PB_WR_LANES*8-1:0]          wr_data_i,
    input  logic                              rd_en_i,
    input  logic [PB_RD_LANES*P_AW-1:0]       rd_addr_i,
    output logic [PB_RD_LANES*8-1:0]          rd_data_o,
    output logic                              rd_valid_o
);

    logic [7:0]               mem_q [P_DEPTH];
    logic [PB_RD_LANES*8-1:0] rd_data_q;
    logic                     rd_valid_q;

    // Higher lanes are applied later, so they win on duplicate addresses.
    always_ff @(posedge clk_i) begin
        for (int n = 0; n < PB_WR_LANES; n++) begin
            if (wr_en_i[n]) begin
                mem_q[wr_addr_i[n*P_AW +: P_AW]] <= wr_data_i[n*8 +: 8];
            end
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            rd_data_q  <= '0;
            rd_valid_q <= 1'b0;
        end else begin
            rd_valid_q <= rd_en_i;
            if (rd_en_i) begin
                for (int c = 0; c < PB_RD_LANES; c++) begin
                    if (int'(rd_addr_i[c*P_AW +: P_AW]) < P_DEPTH) begin
                        rd_data_q[c*8 +: 8] <= mem_q[rd_addr_i[c*P_AW +: P_AW]];
                    end else begin
                        rd_data_q[c*8 +: 8] <= 8'h00;
                    end
                end
            end
        end
    end

    assign rd_data_o  = rd_data_q;
    assign rd_valid_o = rd_valid_q;

endmodule

// File: rtl/pixel_buffer.sv
// 8x8 RGB tile buffer: tracks which bytes were written since the last clear.
//   state      | meaning
//   PB_EMPTY   | no byte written since clear/reset
//   PB_FILLING | some but not all bytes written
//   PB_FULL    | every byte written; overwrites allowed
module pixel_buffer
    import pixel_buffer_pkg::*;
#(
    parameter int P_DEPTH = PB_DEPTH,
    parameter int P_AW    = PB_AW
) (
    input  logic            I_PB_HCLK,
    input  logic            I_PB_RESET,
    input  logic            I_PB_CLEAR,
    input  logic            I_PB_WR_EN,
    input  logic [P_AW-1:0] I_PB_WR_ADDR0,
    input  logic [P_AW-1:0] I_PB_WR_ADDR1,
    input  logic [P_AW-1:0] I_PB_WR_ADDR2,
    input  logic [P_AW-1:0] I_PB_WR_ADDR3,
    input  logic [31:0]     I_PB_WR_DATA,
    input  logic            I_PB_RD_EN,
    input  logic [P_AW-1:0] I_PB_RD_ADDRR,
    input  logic [P_AW-1:0] I_PB_RD_ADDRG,
    input  logic [P_AW-1:0] I_PB_RD_ADDRB,
    output logic [7:0]      O_PB_RD_R,
    output logic [7:0]      O_PB_RD_G,
    output logic [7:0]      O_PB_RD_B,
    output logic            O_PB_RD_VALID,
    output logic            O_PB_FULL,
    output logic [7:0]      O_PB_FILL,
    output logic            O_PB_ERR
);

    logic [P_AW-1:0]          wr_addr [PB_WR_LANES];
    logic [P_AW-1:0]          rd_addr [PB_RD_LANES];
    logic [PB_WR_LANES-1:0]   wr_lane_en;
    logic [PB_WR_LANES-1:0]   lane_dup;
    logic                     wr_err;
    logic                     rd_err;
    logic [2:0]               new_cnt;
    logic [P_DEPTH-1:0]       bits_q, bits_d;
    logic [7:0]               fill_q, fill_d;
    logic                     full_hit;
    logic                     full_q;
    logic                     err_q;
    pb_state_e                state_q;
    logic [PB_RD_LANES*8-1:0] rd_data;

    assign wr_addr[0] = I_PB_WR_ADDR0;
    assign wr_addr[1] = I_PB_WR_ADDR1;
    assign wr_addr[2] = I_PB_WR_ADDR2;
    assign wr_addr[3] = I_PB_WR_ADDR3;

    assign rd_addr[PB_LANE_R] = I_PB_RD_ADDRR;
    assign rd_addr[PB_LANE_G] = I_PB_RD_ADDRG;
    assign rd_addr[PB_LANE_B] = I_PB_RD_ADDRB;

    always_comb begin
        wr_lane_en = '0;
        wr_err     = 1'b0;
        rd_err     = 1'b0;
        for (int n = 0; n < PB_WR_LANES; n++) begin
            if (I_PB_WR_EN) begin
                if (int'(wr_addr[n]) < P_DEPTH) wr_lane_en[n] = 1'b1;
                else                             wr_err        = 1'b1;
            end
        end
        for (int c = 0; c < PB_RD_LANES; c++) begin
            if (I_PB_RD_EN && !(int'(rd_addr[c]) < P_DEPTH)) rd_err = 1'b1;
        end
    end

    // A lane shadowed by a higher lane at the same address must not count twice.
    always_comb begin
        lane_dup = '0;
        for (int n = 0; n < PB_WR_LANES; n++) begin
            for (int m = n + 1; m < PB_WR_LANES; m++) begin
                if (wr_lane_en[m] && (wr_addr[m] == wr_addr[n])) lane_dup[n] = 1'b1;
            end
        end
    end

    always_comb begin
        new_cnt = '0;
        bits_d  = bits_q;
        for (int n = 0; n < PB_WR_LANES; n++) begin
            if (wr_lane_en[n]) begin
                if (!lane_dup[n] && !bits_q[wr_addr[n]]) new_cnt = new_cnt + 3'd1;
                bits_d[wr_addr[n]] = 1'b1;
            end
        end
    end

    assign fill_d   = fill_q + 8'(new_cnt);
    assign full_hit = (fill_d == 8'(P_DEPTH));

    always_ff @(posedge I_PB_HCLK or posedge I_PB_RESET) begin
        if (I_PB_RESET) begin
            state_q <= PB_EMPTY;
            bits_q  <= '0;
            fill_q  <= '0;
            full_q  <= 1'b0;
            err_q   <= 1'b0;
        end else if (I_PB_CLEAR) begin
            state_q <= PB_EMPTY;
            bits_q  <= '0;
            fill_q  <= '0;
            full_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            bits_q <= bits_d;
            fill_q <= fill_d;
            full_q <= full_q | full_hit;
            err_q  <= err_q | wr_err | rd_err;
            case (state_q)
                PB_EMPTY: begin
                    if (full_hit)          state_q <= PB_FULL;
                    else if (new_cnt != 0) state_q <= PB_FILLING;
                end
                PB_FILLING: begin
                    if (full_hit) state_q <= PB_FULL;
                end
                PB_FULL:  state_q <= PB_FULL;
                default:  state_q <= PB_EMPTY;
            endcase
        end
    end

    pixel_buffer_ram #(
        .P_DEPTH (P_DEPTH),
        .P_AW    (P_AW)
    ) u_ram (
        .clk_i      (I_PB_HCLK),
        .rst_i      (I_PB_RESET),
        .wr_en_i    (wr_lane_en),
        .wr_addr_i  ({I_PB_WR_ADDR3, I_PB_WR_ADDR2, I_PB_WR_ADDR1, I_PB_WR_ADDR0}),
        .wr_data_i  (I_PB_WR_DATA),
        .rd_en_i    (I_PB_RD_EN),
        .rd_addr_i  ({rd_addr[2], rd_addr[1], rd_addr[0]}),
        .rd_data_o  (rd_data),
        .rd_valid_o (O_PB_RD_VALID)
    );

    assign O_PB_RD_R = rd_data[PB_LANE_R*8 +: 8];
    assign O_PB_RD_G = rd_data[PB_LANE_G*8 +: 8];
    assign O_PB_RD_B = rd_data[PB_LANE_B*8 +: 8];
    assign O_PB_FULL = full_q;
    assign O_PB_FILL = fill_q;
    assign O_PB_ERR  = err_q;

endmodule

// File: tb/tb_pixel_buffer.sv
// Self-checking bench for pixel_buffer: directed scenarios plus randomized traffic vs a byte-array model.
module tb_pixel_buffer;

    localparam int DEPTH = 192;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        clr = 1'b0;
    logic        wr_en = 1'b0;
    logic [7:0]  wa0 = '0, wa1 = '0, wa2 = '0, wa3 = '0;
    logic [31:0] wdata = '0;
    logic        rd_en = 1'b0;
    logic [7:0]  ra = '0, ga = '0, ba = '0;
    logic [7:0]  rd_r, rd_g, rd_b;
    logic        rd_valid, full, err;
    logic [7:0]  fill;

    int n_tests = 0;
    int n_fail  = 0;

    logic [7:0] mem_m   [DEPTH];
    bit         known_m [DEPTH];
    bit         wrt_m   [DEPTH];
    int         fill_m;
    bit         err_m;
    bit         valid_m;
    logic [7:0] exp_rgb   [3];
    bit         rgb_known [3];

    pixel_buffer dut (
        .I_PB_HCLK     (clk),
        .I_PB_RESET    (rst),
        .I_PB_CLEAR    (clr),
        .I_PB_WR_EN    (wr_en),
        .I_PB_WR_ADDR0 (wa0),
        .I_PB_WR_ADDR1 (wa1),
        .I_PB_WR_ADDR2 (wa2),
        .I_PB_WR_ADDR3 (wa3),
        .I_PB_WR_DATA  (wdata),
        .I_PB_RD_EN    (rd_en),
        .I_PB_RD_ADDRR (ra),
        .I_PB_RD_ADDRG (ga),
        .I_PB_RD_ADDRB (ba),
        .O_PB_RD_R     (rd_r),
        .O_PB_RD_G     (rd_g),
        .O_PB_RD_B     (rd_b),
        .O_PB_RD_VALID (rd_valid),
        .O_PB_FULL     (full),
        .O_PB_FILL     (fill),
        .O_PB_ERR      (err)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < DEPTH; i++) begin
            known_m[i] = 1'b0;
            wrt_m[i]   = 1'b0;
        end
        fill_m  = 0;
        err_m   = 1'b0;
        valid_m = 1'b0;
        for (int c = 0; c < 3; c++) begin
            exp_rgb[c]   = 8'h00;
            rgb_known[c] = 1'b1;
        end
    endtask

    task automatic check_outputs();
        logic [7:0] obs_rgb [3];
        int exp_state;
        obs_rgb[0] = rd_r;
        obs_rgb[1] = rd_g;
        obs_rgb[2] = rd_b;
        exp_state = (fill_m == 0) ? 0 : (fill_m == DEPTH) ? 2 : 1;
        check_val("valid", 32'(rd_valid), 32'(valid_m));
        check_val("fill", 32'(fill), 32'(fill_m));
        check_val("full", 32'(full), 32'(fill_m == DEPTH));
        check_val("err", 32'(err), 32'(err_m));
        check_val("state", 32'(dut.state_q), 32'(exp_state));
        for (int c = 0; c < 3; c++) begin
            if (rgb_known[c]) check_val($sformatf("rgb%0d", c), 32'(obs_rgb[c]), 32'(exp_rgb[c]));
        end
    endtask

    // Drive one cycle, advance the model by the same edge, then sample just after it.
    task automatic cycle(input bit c_clr, input bit c_we,
                         input logic [7:0] a0, input logic [7:0] a1,
                         input logic [7:0] a2, input logic [7:0] a3,
                         input logic [31:0] d, input bit c_re,
                         input logic [7:0] r, input logic [7:0] g, input logic [7:0] b);
        logic [7:0] wa [4];
        logic [7:0] rda [3];
        bit rd_err, wr_err;
        int cnt;
        wa[0] = a0; wa[1] = a1; wa[2] = a2; wa[3] = a3;
        rda[0] = r; rda[1] = g; rda[2] = b;
        clr = c_clr; wr_en = c_we; wa0 = a0; wa1 = a1; wa2 = a2; wa3 = a3;
        wdata = d; rd_en = c_re; ra = r; ga = g; ba = b;

        rd_err = 1'b0;
        valid_m = c_re;
        if (c_re) begin
            for (int c = 0; c < 3; c++) begin
                if (int'(rda[c]) >= DEPTH) begin
                    exp_rgb[c] = 8'h00; rgb_known[c] = 1'b1; rd_err = 1'b1;
                end else begin
                    exp_rgb[c] = mem_m[rda[c]]; rgb_known[c] = known_m[rda[c]];
                end
            end
        end
        wr_err = 1'b0;
        if (c_we) begin
            for (int n = 0; n < 4; n++) begin
                if (int'(wa[n]) < DEPTH) begin
                    mem_m[wa[n]] = d[8*n +: 8];
                    known_m[wa[n]] = 1'b1;
                    wrt_m[wa[n]] = 1'b1;
                end else begin
                    wr_err = 1'b1;
                end
            end
        end
        if (c_clr) begin
            for (int i = 0; i < DEPTH; i++) wrt_m[i] = 1'b0;
            err_m = 1'b0;
        end else begin
            err_m = err_m | rd_err | wr_err;
        end
        cnt = 0;
        for (int i = 0; i < DEPTH; i++) if (wrt_m[i]) cnt++;
        fill_m = cnt;

        @(posedge clk);
        #1;
        check_outputs();
    endtask

    task automatic idle();
        cycle(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic reset_checks(input string tag);
        check_val({tag, "_r"}, 32'(rd_r), 32'h0);
        check_val({tag, "_g"}, 32'(rd_g), 32'h0);
        check_val({tag, "_b"}, 32'(rd_b), 32'h0);
        check_val({tag, "_valid"}, 32'(rd_valid), 32'h0);
        check_val({tag, "_full"}, 32'(full), 32'h0);
        check_val({tag, "_fill"}, 32'(fill), 32'h0);
        check_val({tag, "_err"}, 32'(err), 32'h0);
        check_val({tag, "_state"}, 32'(dut.state_q), 32'h0);
    endtask

    initial begin
        logic [7:0] a [4];
        logic [7:0] r [3];
        logic [31:0] d;

        model_reset();
        #12;
        reset_checks("reset");
        @(negedge clk);
        rst = 1'b0;

        // Fill the whole tile with data = address, four bytes per word.
        for (int k = 0; k < 48; k++) begin
            for (int n = 0; n < 4; n++) a[n] = 8'(4 * k + n);
            cycle(0, 1, a[0], a[1], a[2], a[3], {a[3], a[2], a[1], a[0]}, 0, 0, 0, 0);
            check_val("fill_step", 32'(fill), 32'(4 * (k + 1)));
            check_val("full_on_48", 32'(full), 32'(k == 47));
        end

        cycle(0, 0, 0, 0, 0, 0, 0, 1, 8'h15, 8'h16, 8'h17);
        check_val("rd_15", 32'(rd_r), 32'h15);
        check_val("rd_16", 32'(rd_g), 32'h16);
        check_val("rd_17", 32'(rd_b), 32'h17);
        check_val("rd_valid", 32'(rd_valid), 32'h1);
        idle();
        check_val("hold_r", 32'(rd_r), 32'h15);
        check_val("valid_low", 32'(rd_valid), 32'h0);

        // Read-first on a same-cycle read/write collision.
        cycle(0, 1, 0, 0, 0, 0, 32'hAAAA_AAAA, 1, 0, 0, 0);
        check_val("rdfirst_old", 32'(rd_r), 32'h00);
        cycle(0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0);
        check_val("rdfirst_new", 32'(rd_r), 32'hAA);
        check_val("full_kept", 32'(full), 32'h1);

        // Straddling the top of the buffer: two lanes land, two are dropped.
        cycle(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        cycle(0, 1, 8'hBE, 8'hBF, 8'hC0, 8'hC1, 32'h4433_2211, 0, 0, 0, 0);
        check_val("oor_err", 32'(err), 32'h1);
        check_val("oor_fill", 32'(fill), 32'h2);
        cycle(0, 0, 0, 0, 0, 0, 0, 1, 8'hBE, 8'hBF, 8'hC0);
        check_val("oor_be", 32'(rd_r), 32'h11);
        check_val("oor_bf", 32'(rd_g), 32'h22);
        check_val("oor_rd0", 32'(rd_b), 32'h00);

        // Clear wins over a same-cycle write but the data is still stored.
        cycle(1, 1, 8'h10, 8'h10, 8'h10, 8'h10, 32'h5A5A_5A5A, 0, 0, 0, 0);
        check_val("clr_fill", 32'(fill), 32'h0);
        check_val("clr_err", 32'(err), 32'h0);
        check_val("clr_state", 32'(dut.state_q), 32'h0);
        cycle(0, 0, 0, 0, 0, 0, 0, 1, 8'h10, 8'h10, 8'h10);
        check_val("clr_data", 32'(rd_r), 32'h5A);

        // Duplicate addresses in one word: highest lane wins, counted once.
        cycle(0, 1, 8'h20, 8'h21, 8'h20, 8'h20, 32'h0403_0201, 0, 0, 0, 0);
        check_val("dup_fill", 32'(fill), 32'h2);
        cycle(0, 0, 0, 0, 0, 0, 0, 1, 8'h20, 8'h21, 8'h20);
        check_val("dup_data", 32'(rd_r), 32'h04);

        for (int it = 0; it < 400; it++) begin
            for (int n = 0; n < 4; n++) a[n] = 8'($urandom_range(0, 199));
            if ($urandom_range(0, 7) == 0) a[3] = a[0];
            for (int c = 0; c < 3; c++) r[c] = 8'($urandom_range(0, 199));
            d = $urandom;
            cycle($urandom_range(0, 39) == 0, $urandom_range(0, 2) != 0,
                  a[0], a[1], a[2], a[3], d, $urandom_range(0, 1) == 1, r[0], r[1], r[2]);
        end

        // Reset mid-fill, asserted between clock edges.
        cycle(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        for (int k = 0; k < 16; k++) begin
            for (int n = 0; n < 4; n++) a[n] = 8'(4 * k + n);
            cycle(0, 1, a[0], a[1], a[2], a[3], 32'hC0DE_0000 + 32'(k), k == 15, 1, 2, 3);
        end
        check_val("mid_fill", 32'(fill), 32'h40);
        #2;
        rst = 1'b1;
        #1;
        reset_checks("midrst");
        model_reset();
        @(negedge clk);
        rst = 1'b0;
        for (int it = 0; it < 40; it++) begin
            for (int n = 0; n < 4; n++) a[n] = 8'($urandom_range(0, 195));
            for (int c = 0; c < 3; c++) r[c] = 8'($urandom_range(0, 195));
            cycle(0, 1, a[0], a[1], a[2], a[3], $urandom, 1, r[0], r[1], r[2]);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
